// File: rtl/dram_byte_ctrl.sv
// Byte-addressable 32-bit word memory with byte/half/word access, load extension,
// and a post-reset init sweep that fills every word with INIT_VAL.
module dram_byte_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] INIT_VAL = 32'hAAAAAAAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWR,
  input  logic [1:0]        MemSize,
  input  logic              LoadSigned,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busy,
  output logic              misalign,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;

  logic [31:0]       mem_q [DEPTH];

  size_e             size;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              store_ok;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  assign size     = size_e'(MemSize);
  assign word_idx = addr[ADDR_W+1:2];
  assign byte_off = addr[1:0];

  assign busy     = (state_q == ST_INIT);
  assign wr_drop  = wr_drop_q;

  // Alignment fault: halves need an even offset, words need offset zero.
  always_comb begin
    misalign = 1'b0;
    unique case (size)
      SZ_BYTE:              misalign = 1'b0;
      SZ_HALF:              misalign = byte_off[0];
      SZ_WORD, SZ_WORD_ALT: misalign = |byte_off;
    endcase
  end

  assign store_ok  = (state_q == ST_RUN) && MemWR && !misalign;
  assign wr_drop_d = MemWR && (busy || misalign);

  // NOTE: every output of a combinational block gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Single write port shared by the init sweep and accepted stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_be    = 4'b0000;
    mem_wdata = writedata;
    if (busy) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_be    = 4'b1111;
      mem_wdata = INIT_VAL;
    end else if (store_ok) begin
      mem_we = 1'b1;
      unique case (size)
        SZ_BYTE: begin
          mem_be    = 4'b0001 << byte_off;
          mem_wdata = {4{writedata[7:0]}};
        end
        SZ_HALF: begin
          mem_be    = byte_off[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{writedata[15:0]}};
        end
        SZ_WORD, SZ_WORD_ALT: begin
          mem_be    = 4'b1111;
          mem_wdata = writedata;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are defined only by the init
  // sweep, and rst merely holds off writes while asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = busy ? INIT_VAL : mem_q[word_idx];
  assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign rd_half = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    readdata = 32'h0;
    if (!misalign) begin
      unique case (size)
        SZ_BYTE:              readdata = {{24{LoadSigned & rd_byte[7]}}, rd_byte};
        SZ_HALF:              readdata = {{16{LoadSigned & rd_half[15]}}, rd_half};
        SZ_WORD, SZ_WORD_ALT: readdata = rd_word;
      endcase
    end
  end

endmodule

// File: doc/dram_byte_ctrl.md
DRAM_BYTE_CTRL -- requirements
Module: dram_byte_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning word-address width (depth DEPTH = 2**ADDR_W words of 32 bits).
REQ-002 The block SHALL have parameter INIT_VAL, default 32'hAAAAAAAA, meaning the fill value written by the init sweep.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port MemWR, input, 1 bit: store request for the current cycle.
REQ-006 The block SHALL have port MemSize, input, 2 bits: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 The block SHALL have port LoadSigned, input, 1 bit: 1 selects sign-extension and 0 selects zero-extension for byte/half reads.
REQ-008 The block SHALL have port addr, input, ADDR_W+2 bits: byte address, where addr[ADDR_W+1:2] is the word index and addr[1:0] is the byte offset.
REQ-009 The block SHALL have port writedata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 The block SHALL have port readdata, output, 32 bits: combinational load result.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the init sweep runs.
REQ-012 The block SHALL have port misalign, output, 1 bit: combinational alignment fault for the current access.
REQ-013 The block SHALL have port wr_drop, output, 1 bit: registered one-cycle pulse marking a rejected store.

Function
REQ-014 The block SHALL implement a two-state FSM {INIT, RUN} with a counter cnt of ADDR_W bits.
REQ-015 In INIT, each rising edge SHALL write INIT_VAL to mem[cnt] and then increment cnt.
REQ-016 On the edge that writes mem[DEPTH-1], the FSM SHALL move to RUN and cnt SHALL wrap to 0.
REQ-017 busy SHALL equal (state == INIT), so it stays high for exactly DEPTH rising edges after rst deasserts.
REQ-018 misalign SHALL be 1 for half accesses with addr[0]=1, and for word accesses (MemSize 10 or 11) with addr[1:0]!=0; it SHALL be 0 for all byte accesses.
REQ-019 A store SHALL be accepted only when state==RUN, MemWR=1 and misalign=0.
REQ-020 An accepted byte store SHALL write writedata[7:0] into lane addr[1:0].
REQ-021 An accepted half store SHALL write writedata[15:0] into lanes {addr[1],1} and {addr[1],0}.
REQ-022 An accepted word store SHALL write all four lanes; lanes not written SHALL keep their contents.
REQ-023 MemWR=1 while busy=1 or misalign=1 SHALL leave memory unchanged and set wr_drop=1 for the following cycle only; wr_drop SHALL be 0 otherwise.
REQ-024 Reads SHALL be asynchronous: word W = busy ? INIT_VAL : mem[addr[ADDR_W+1:2]].
REQ-025 For a byte read, readdata SHALL be the lane addr[1:0] of W, extended to 32 bits per LoadSigned.
REQ-026 For a half read, readdata SHALL be half addr[1] of W, extended to 32 bits per LoadSigned.
REQ-027 For a word read, readdata SHALL be W.
REQ-028 A misaligned read SHALL return readdata=32'h0.
REQ-029 A read and a write to the same word in the same cycle SHALL return the pre-edge contents; the new value SHALL be visible after the edge.
REQ-030 The FSM SHALL never hold INIT for more than DEPTH edges without a reset.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) force state=INIT, cnt=0, busy=1 and wr_drop=0.
REQ-032 Memory contents SHALL NOT be cleared asynchronously by rst; only the sweep writes them.
REQ-033 rst asserted mid-sweep SHALL restart the sweep from word 0; rst asserted in RUN SHALL re-run the full sweep.
REQ-034 The sweep SHALL begin on the first rising edge at which rst=0.

Verification
REQ-035 Bench scenario, reset and sweep, default parameters: pulse rst, then release -> busy=1 for exactly 32 edges then 0, and reading any word address gives 32'hAAAAAAAA.
REQ-036 Bench scenario, byte/half stores: word store 0x11223344 @0; byte store 0xEE @2; half store 0x8001 @0 -> word read @0 = 0x11EE8001.
REQ-037 Bench scenario, load extension: with word 0x11EE8001 at @0, byte read @2 with LoadSigned=1 -> 0xFFFFFFEE; LoadSigned=0 -> 0x000000EE; half read @0 signed -> 0xFFFF8001.
REQ-038 Bench scenario, misaligned access: half store @1 -> misalign=1, wr_drop=1 on the next cycle, memory unchanged; word read @2 -> readdata=0.
REQ-039 Bench scenario, store while busy: MemWR=1 at cycle 3 of the sweep -> write dropped, wr_drop pulses once, and the word reads 0xAAAAAAAA after the sweep.
REQ-040 Bench scenario, reset mid-sweep and wrap: rst at cycle 10 of the sweep -> busy lasts a fresh 32 edges after release; word store @124 (word 31) and reread -> data correct with no alias to word 0.
